// File: rtl/pattern_detector_if.sv
// Serial-in / match-out bundle for pattern_detector.
// master drives sig and watches out; slave is the detector.
interface pattern_detector_if;
  logic sig;
  logic out;

  modport master (
    output sig,
    input  out
  );

  modport slave (
    input  sig,
    output out
  );
endinterface

// File: rtl/pattern_detector.sv
// Serial pattern detector with a stretched, registered match flag.
// `PATTERN_OVERLAP_EN selects overlapping matches (fill keeps running).
module pattern_detector #(
  parameter int unsigned PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN = 4'b1001,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  pattern_detector_if.slave bus
);

  localparam int unsigned FW = $clog2(PATTERN_LEN + 1);
  localparam int unsigned HW = 8;

  logic [PATTERN_LEN-1:0] hist_q, hist_d;
  logic [PATTERN_LEN:0]   shift_w;
  logic [FW-1:0]          fill_q, fill_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   out_q, out_d;
  logic                   match_w;

  // Window including the bit sampled on this edge; works for PATTERN_LEN=1.
  assign shift_w = {hist_q, bus.sig};
  assign hist_d  = shift_w[PATTERN_LEN-1:0];

  assign match_w = (hist_d == PATTERN) &&
                   (fill_q >= FW'(PATTERN_LEN - 1));

  always_comb begin
    fill_d = fill_q;
    hold_d = '0;
    out_d  = 1'b0;

    if (fill_q != FW'(PATTERN_LEN)) begin
      fill_d = fill_q + FW'(1);
    end
`ifndef PATTERN_OVERLAP_EN
    if (match_w) begin
      fill_d = '0;
    end
`endif

    if (match_w) begin
      hold_d = HW'(HOLD_CYCLES);
      out_d  = 1'b1;
    end else if (hold_q > HW'(1)) begin
      hold_d = hold_q - HW'(1);
      out_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      hold_q <= '0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      hold_q <= hold_d;
      out_q  <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Scoreboard bench for pattern_detector: three parameter sets,
// one shared serial stream, expectations from an edge-index model.
module tb_pattern_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_r = 1'b0;

  always #5 clk = ~clk;

  pattern_detector_if if_a ();
  pattern_detector_if if_b ();
  pattern_detector_if if_c ();

  assign if_a.sig = sig_r;
  assign if_b.sig = sig_r;
  assign if_c.sig = sig_r;

  pattern_detector #(
    .PATTERN_LEN(4), .PATTERN(4'b1001), .HOLD_CYCLES(4)
  ) u_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );

  pattern_detector #(
    .PATTERN_LEN(4), .PATTERN(4'b1001), .HOLD_CYCLES(1)
  ) u_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );

  pattern_detector #(
    .PATTERN_LEN(4), .PATTERN(4'b0001), .HOLD_CYCLES(2)
  ) u_c (
    .clk(clk), .rst(rst), .bus(if_c.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];

  int pat[3] = '{9, 9, 1};
  int hld[3] = '{4, 1, 2};

  // Per instance: last 4 samples as a number, samples
  // counted since reset/clear, edge index of last match.
  int mv[3] = '{0, 0, 0};
  int mc[3] = '{0, 0, 0};
  int ml[3] = '{-1000, -1000, -1000};
  int edge_n = 0;

  task automatic step(input logic r, input logic s);
    logic [2:0] e;
    rst   = r;
    sig_r = s;
    edge_n++;
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        mv[d] = 0;
        mc[d] = 0;
        ml[d] = -1000;
      end else begin
        mv[d] = ((mv[d] << 1) | int'(s)) & 15;
        mc[d]++;
        if (mc[d] >= 4 && mv[d] == pat[d]) begin
          ml[d] = edge_n;
`ifndef PATTERN_OVERLAP_EN
          mc[d] = 0;
`endif
        end
      end
      e[d] = ((edge_n - ml[d]) < hld[d]);
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic feed(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, v[i]);
    end
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0);
    end
  endtask

  // Monitor: one expected triple per rising edge.
  initial begin
    logic [2:0] e;
    logic [2:0] a;
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      a = {if_c.out, if_b.out, if_a.out};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty cyc=%0d got=%b", cyc, a);
      end else begin
        e = exp_q.pop_front();
        for (int d = 0; d < 3; d++) begin
          total++;
          if (a[d] !== e[d]) begin
            bad++;
            $display("FAIL out_dut%0d cyc=%0d got=%b want=%b",
                     d, cyc, a[d], e[d]);
          end
        end
      end
    end
  end

  initial begin
    logic r;
    logic s;

    step(1'b1, 1'b0);
    zeros(10);

    step(1'b1, 1'b0);
    feed(32'b10010, 5);
    zeros(50);

    step(1'b1, 1'b0);
    feed(32'b10100110010, 11);
    zeros(6);

    step(1'b1, 1'b0);
    feed(32'b1, 1);
    zeros(3);
    step(1'b1, 1'b0);
    feed(32'b0001, 4);
    zeros(4);

    step(1'b1, 1'b0);
    feed(32'b1001001, 7);
    zeros(4);
    feed(32'b10011001, 8);
    zeros(4);

    step(1'b1, 1'b0);
    feed(32'b10010, 5);
    step(1'b1, 1'b0);
    feed(32'b001, 3);
    zeros(5);

    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 59) == 0);
      s = 1'($urandom_range(0, 1));
      step(r, s);
    end

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
